// File: rtl/mat_mul_sched.sv
// Sequencing controller for the matrix-multiply datapath.
// It issues all DIM*DIM (row, col) dot-product jobs into the multiplier and
// adder-tree pipe and counts the jobs that are still in flight. It turns the
// returning write enables into result-memory addresses and pulses done when
// the last result is written.
module mat_mul_sched #(
    parameter int DIM      = 8,
    parameter int IDX_W    = 3,
    parameter int PIPE_LAT = 4,
    parameter int CNT_W    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               operand_rdy,
    input  logic               pipe_we_out,
    output logic               issue_we,
    output logic [IDX_W-1:0]   row_idx,
    output logic [IDX_W-1:0]   col_idx,
    output logic               res_we,
    output logic [2*IDX_W-1:0] res_addr,
    output logic               busy,
    output logic               done,
    output logic               err_spurious
);

    // The scheduler matches returns to jobs by count, so it never needs the
    // pipe latency. The latency is kept only as a record of the pipe depth.
    localparam int PIPE_LAT_UNUSED = PIPE_LAT;

    localparam logic [CNT_W-1:0] LAST_JOB = CNT_W'(DIM * DIM - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   issue_cnt_reg, issue_cnt_next;
    logic [CNT_W-1:0]   rcv_cnt_reg, rcv_cnt_next;
    logic [CNT_W-1:0]   inflight_reg, inflight_next;
    logic               busy_reg, done_reg;
    logic               res_we_reg;
    logic [2*IDX_W-1:0] res_addr_reg;
    logic               err_reg;

    logic issue_fire;
    logic ret_accept;
    logic ret_spurious;
    logic start_accept;

    // Qualify the raw handshakes. A return counts only while a pass is running
    // and at least one job is still in the pipe. Every other return is spurious.
    always_comb begin
        start_accept = (state_reg == IDLE) && start;
        issue_fire   = (state_reg == ISSUE) && operand_rdy;
        ret_accept   = pipe_we_out && (inflight_reg != '0)
                       && ((state_reg == ISSUE) || (state_reg == DRAIN));
        ret_spurious = pipe_we_out && !ret_accept;
    end

    // Next-state and counter update. The final accepted return forces DONE.
    // This gives it priority over the ISSUE->DRAIN move, so done always
    // coincides with the 64th result write.
    always_comb begin
        state_next     = state_reg;
        issue_cnt_next = issue_cnt_reg;
        rcv_cnt_next   = rcv_cnt_reg;
        inflight_next  = inflight_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = ISSUE;
                    issue_cnt_next = '0;
                    rcv_cnt_next   = '0;
                    inflight_next  = '0;
                end
            end
            ISSUE: begin
                if (issue_fire) begin
                    issue_cnt_next = issue_cnt_reg + CNT_ONE;
                    if (issue_cnt_reg == LAST_JOB) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = DRAIN;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (ret_accept) begin
            rcv_cnt_next = rcv_cnt_reg + CNT_ONE;
            if (rcv_cnt_reg == LAST_JOB) begin
                state_next = DONE;
            end
        end

        // An issue and a return in the same cycle cancel out.
        if (issue_fire && !ret_accept) begin
            inflight_next = inflight_reg + CNT_ONE;
        end else if (!issue_fire && ret_accept) begin
            inflight_next = inflight_reg - CNT_ONE;
        end
    end

    // State register and job counters.
    // busy and done are registered together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            issue_cnt_reg <= '0;
            rcv_cnt_reg   <= '0;
            inflight_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            issue_cnt_reg <= issue_cnt_next;
            rcv_cnt_reg   <= rcv_cnt_next;
            inflight_reg  <= inflight_next;
            busy_reg      <= (state_next == ISSUE) || (state_next == DRAIN);
            done_reg      <= (state_next == DONE);
        end
    end

    // Result-memory write port and the sticky spurious-return flag.
    // Results come back in issue order, so the receive count is the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_we_reg   <= 1'b0;
            res_addr_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            res_we_reg <= ret_accept;
            if (ret_accept) begin
                res_addr_reg <= rcv_cnt_reg[2*IDX_W-1:0];
            end
            if (start_accept) begin
                err_reg <= 1'b0;
            end else if (ret_spurious) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Column index changes fastest: the low index bits are col, the next bits are row.
    always_comb begin
        issue_we     = issue_fire;
        row_idx      = issue_cnt_reg[2*IDX_W-1:IDX_W];
        col_idx      = issue_cnt_reg[IDX_W-1:0];
        res_we       = res_we_reg;
        res_addr     = res_addr_reg;
        busy         = busy_reg;
        done         = done_reg;
        err_spurious = err_reg;
    end

endmodule

// File: tb/tb_mat_mul_sched.sv
// Testbench for mat_mul_sched. A fixed 4-cycle shift register stands in for
// the multiply / adder-tree pipe. Each pass is recorded cycle by cycle and
// compared with the expected schedule. That schedule comes from the
// operand_rdy history the bench drove itself.
module tb_mat_mul_sched;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       operand_rdy;
    logic       pipe_we_out;
    logic       issue_we;
    logic [2:0] row_idx;
    logic [2:0] col_idx;
    logic       res_we;
    logic [5:0] res_addr;
    logic       busy;
    logic       done;
    logic       err_spurious;

    logic [3:0] pipe_sr = '0;
    logic       inj = 1'b0;

    int total = 0;
    int bad   = 0;

    mat_mul_sched #(
        .DIM(8), .IDX_W(3), .PIPE_LAT(4), .CNT_W(7)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .operand_rdy(operand_rdy),
        .pipe_we_out(pipe_we_out),
        .issue_we(issue_we),
        .row_idx(row_idx),
        .col_idx(col_idx),
        .res_we(res_we),
        .res_addr(res_addr),
        .busy(busy),
        .done(done),
        .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipe model: issue_we reappears 4 cycles later. The pipe is not reset.
    always @(posedge clk) pipe_sr <= {pipe_sr[2:0], issue_we};
    assign pipe_we_out = pipe_sr[3] | inj;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Run one full pass and check the issue schedule, the result schedule and completion.
    // mode 0: rdy always high; 1: pattern 1,0,0; 2: random.
    task automatic test_pass(input string name, input int mode, input int restart_at);
        int   rdy_q[$];
        int   iss_cyc[$];
        int   iss_row[$];
        int   iss_col[$];
        int   res_cyc[$];
        int   res_adr[$];
        int   done_cyc[$];
        int   busy_done[$];
        int   exp_cyc[$];
        int   infl;
        int   max_infl;
        int   done_limit;
        bit   restarted;
        logic [5:0] exp_ix;
        infl = 0; max_infl = 0; done_limit = -1; restarted = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            if (restart_at >= 0 && !restarted && cyc > 0 && iss_cyc.size() == restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            case (mode)
                0:       operand_rdy = (cyc > 0);
                1:       operand_rdy = (cyc > 0) && ((cyc - 1) % 3 == 0);
                default: operand_rdy = (cyc > 0) && ($urandom_range(0, 1) == 1);
            endcase
            rdy_q.push_back(int'(operand_rdy));
            #1;
            if (busy && !issue_we && iss_cyc.size() < 64) begin
                exp_ix = 6'(iss_cyc.size());
                total++;
                if ({row_idx, col_idx} !== exp_ix) begin
                    bad++;
                    $display("FAIL %s idx_hold cyc=%0d got r=%0d c=%0d want r=%0d c=%0d",
                             name, cyc, row_idx, col_idx, exp_ix[5:3], exp_ix[2:0]);
                end
            end
            if (mode == 0 && issue_we && pipe_we_out) begin
                total++;
                assert (infl == 4) else begin
                    bad++;
                    $display("FAIL %s steady_inflight cyc=%0d got %0d want 4", name, cyc, infl);
                end
            end
            if (issue_we) begin
                iss_cyc.push_back(cyc);
                iss_row.push_back(int'(row_idx));
                iss_col.push_back(int'(col_idx));
            end
            if (res_we) begin
                res_cyc.push_back(cyc);
                res_adr.push_back(int'(res_addr));
            end
            if (done) begin
                done_cyc.push_back(cyc);
                busy_done.push_back(int'(busy));
                if (done_limit < 0) done_limit = cyc + 4;
            end
            infl = infl + int'(issue_we) - int'(pipe_we_out);
            if (infl > max_infl) max_infl = infl;
            if (done_limit >= 0 && cyc >= done_limit) break;
        end
        start = 1'b0;
        operand_rdy = 1'b0;

        if (done_limit < 0) begin
            total++; bad++;
            $display("FAIL %s timeout: no done within cycle budget", name);
        end
        // Expected schedule: the k-th job issues on the k-th rdy cycle after start.
        for (int c = 1; c < rdy_q.size() && exp_cyc.size() < 64; c++)
            if (rdy_q[c] == 1) exp_cyc.push_back(c);

        total++;
        if (iss_cyc.size() !== 64) begin
            bad++;
            $display("FAIL %s issue_count got %0d want 64", name, iss_cyc.size());
        end
        for (int k = 0; k < iss_cyc.size() && k < exp_cyc.size(); k++) begin
            total++;
            if (iss_cyc[k] !== exp_cyc[k] || iss_row[k] !== k / 8 || iss_col[k] !== k % 8) begin
                bad++;
                $display("FAIL %s issue job=%0d got cyc=%0d r=%0d c=%0d want cyc=%0d r=%0d c=%0d",
                         name, k, iss_cyc[k], iss_row[k], iss_col[k], exp_cyc[k], k / 8, k % 8);
            end
        end
        total++;
        if (res_cyc.size() !== 64) begin
            bad++;
            $display("FAIL %s result_count got %0d want 64", name, res_cyc.size());
        end
        for (int k = 0; k < res_cyc.size() && k < iss_cyc.size(); k++) begin
            total++;
            if (res_adr[k] !== k || res_cyc[k] !== iss_cyc[k] + 5) begin
                bad++;
                $display("FAIL %s result n=%0d got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                         name, k, res_adr[k], res_cyc[k], k, iss_cyc[k] + 5);
            end
        end
        total++;
        if (done_cyc.size() !== 1) begin
            bad++;
            $display("FAIL %s done_count got %0d want 1", name, done_cyc.size());
        end
        if (done_cyc.size() >= 1 && res_cyc.size() >= 64) begin
            total++;
            if (done_cyc[0] !== res_cyc[63]) begin
                bad++;
                $display("FAIL %s done_timing got cyc=%0d want cyc=%0d", name, done_cyc[0], res_cyc[63]);
            end
            total++;
            if (busy_done[0] !== 0) begin
                bad++;
                $display("FAIL %s busy_at_done got %0d want 0", name, busy_done[0]);
            end
        end
        if (mode == 1) begin
            total++;
            if (max_infl > 4) begin
                bad++;
                $display("FAIL %s max_inflight got %0d want <=4", name, max_infl);
            end
        end
        total++;
        if (err_spurious !== 1'b0) begin
            bad++;
            $display("FAIL %s err_after_pass got %0b want 0", name, err_spurious);
        end
        $display("%s: issued=%0d results=%0d dones=%0d", name, iss_cyc.size(), res_cyc.size(), done_cyc.size());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; operand_rdy = 1'b0; inj = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({issue_we, row_idx, col_idx, res_we, res_addr, busy, done, err_spurious} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got %b want all zero",
                     {issue_we, row_idx, col_idx, res_we, res_addr, busy, done, err_spurious});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || issue_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%0b issue_we=%0b want 0 0", busy, issue_we);
        end
        $display("reset: done");
    endtask

    task automatic test_spurious_idle();
        bit saw_res;
        saw_res = 1'b0;
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        #1;
        if (res_we) saw_res = 1'b1;
        total++;
        if (err_spurious !== 1'b1) begin
            bad++;
            $display("FAIL spurious_set got %0b want 1", err_spurious);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            if (res_we) saw_res = 1'b1;
        end
        total++;
        if (saw_res) begin
            bad++;
            $display("FAIL spurious_no_res got res_we=1 want 0");
        end
        total++;
        if (err_spurious !== 1'b1) begin
            bad++;
            $display("FAIL spurious_sticky got %0b want 1", err_spurious);
        end
        @(negedge clk);
        start = 1'b1; operand_rdy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (err_spurious !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL spurious_clear got err=%0b busy=%0b want 0 1", err_spurious, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("spurious_idle: done");
    endtask

    task automatic test_reset_mid();
        bit found;
        bit saw_res;
        bit saw_done;
        found = 1'b0; saw_res = 1'b0; saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; operand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (issue_we && {row_idx, col_idx} == 6'd30) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reset_mid_reach got no job 30 want job 30 issued");
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({issue_we, row_idx, col_idx, res_we, res_addr, busy, done, err_spurious} !== 19'd0) begin
            bad++;
            $display("FAIL reset_mid_async got %b want all zero",
                     {issue_we, row_idx, col_idx, res_we, res_addr, busy, done, err_spurious});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; operand_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (res_we) saw_res = 1'b1;
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        total++;
        if (saw_res || saw_done) begin
            bad++;
            $display("FAIL reset_mid_quiet got res_we=%0b done=%0b want 0 0", saw_res, saw_done);
        end
        total++;
        if (err_spurious !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_residue got err=%0b want 1", err_spurious);
        end
        $display("reset_mid: aborted at job 30");
        test_pass("after_reset", 2, -1);
    endtask

    initial begin
        start = 1'b0; operand_rdy = 1'b0; rst_n = 1'b0;
        test_reset();
        test_pass("full_rate", 0, -1);
        test_pass("gapped", 1, -1);
        test_pass("start_ignored", 0, 10);
        test_pass("random_rdy", 2, 10);
        test_spurious_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
